// File: rtl/store_commit_queue_pkg.sv
// Shared types for the store commit queue: entry layout, drain FSM states and
// word-address helper used by both the drain path and the forwarding lookup.
package store_commit_queue_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } store_entry_t;

    typedef enum logic {
        SQ_IDLE,
        SQ_ISSUE
    } sq_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/store_commit_queue_fwd_match.sv
// Youngest-match store-to-load forwarding select over the live entries
// (head..tail-1); only instantiated when STORE_FWD_EN is defined.
module sq_fwd_match
    import store_commit_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  store_entry_t      entries [DEPTH],
    input  logic [PTR_W:0]    head,
    input  logic [PTR_W:0]    tail,
    input  logic [31:0]       ld_addr,
    output logic              hit,
    output logic [31:0]       data,
    output logic [3:0]        be
);
    typedef logic [PTR_W:0] ptr_t;

    ptr_t used;
    ptr_t idx;

    // Walk oldest to youngest so the last match found wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        be   = '0;
        idx  = '0;
        used = tail - head;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + ptr_t'(k);
            if ((ptr_t'(k) < used) &&
                (word_align(entries[idx[PTR_W-1:0]].addr) == word_align(ld_addr))) begin
                hit  = 1'b1;
                data = entries[idx[PTR_W-1:0]].data;
                be   = entries[idx[PTR_W-1:0]].be;
            end
        end
    end

endmodule

// File: rtl/store_commit_queue.sv
// Store commit queue: buffers LSU stores until commit, then drains committed
// stores in order to the D-cache. Optional forwarding port under STORE_FWD_EN.
module store_commit_queue
    import store_commit_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        enq_valid,
    output logic        enq_ready,
    input  logic [31:0] enq_addr,
    input  logic [31:0] enq_data,
    input  logic [3:0]  enq_be,
    input  logic [1:0]  commit_cnt,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_be,
    output logic        empty,
    output logic        commit_err
`ifdef STORE_FWD_EN
    ,
    input  logic [31:0] ld_addr,
    output logic        fwd_hit,
    output logic [31:0] fwd_data,
    output logic [3:0]  fwd_be
`endif
);
    typedef logic [PTR_W:0] ptr_t;

    store_entry_t mem [DEPTH];
    store_entry_t load_ent;
    sq_state_t    state, state_nxt;

    ptr_t head, cmt, tail;
    ptr_t head_nxt, cmt_nxt, tail_nxt;
    ptr_t uncmt, cnt_ext, adv, load_ptr;
    logic full, enq_fire, pop, load;

    // Pointer arithmetic is modulo 2^(PTR_W+1); the extra MSB separates full from empty.
    assign full      = ((tail - head) == ptr_t'(DEPTH));
    assign enq_ready = !full;
    assign empty     = (tail == head);
    assign enq_fire  = enq_valid && enq_ready && !flush;
    assign uncmt     = tail - cmt;
    assign cnt_ext   = ptr_t'(commit_cnt);
    assign adv       = (cnt_ext > uncmt) ? uncmt : cnt_ext;
    assign cmt_nxt   = cmt + adv;
    assign wr_valid  = (state == SQ_ISSUE);
    assign pop       = wr_valid && wr_ready;
    assign head_nxt  = head + ptr_t'(pop);
    // Flush keeps everything committed up to and including this cycle's commit.
    assign tail_nxt  = flush ? cmt_nxt : (tail + ptr_t'(enq_fire));
    assign load_ent  = mem[load_ptr[PTR_W-1:0]];

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_ptr  = head;
        case (state)
            SQ_IDLE: begin
                if (cmt != head) begin
                    load      = 1'b1;
                    state_nxt = SQ_ISSUE;
                end
            end
            SQ_ISSUE: begin
                if (wr_ready) begin
                    if (cmt != head_nxt) begin
                        load     = 1'b1;
                        load_ptr = head_nxt;
                    end else begin
                        state_nxt = SQ_IDLE;
                    end
                end
            end
            default: state_nxt = SQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            cmt        <= '0;
            tail       <= '0;
            state      <= SQ_IDLE;
            commit_err <= 1'b0;
        end else begin
            head  <= head_nxt;
            cmt   <= cmt_nxt;
            tail  <= tail_nxt;
            state <= state_nxt;
            if (cnt_ext > uncmt) commit_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) mem[tail[PTR_W-1:0]] <= '{addr: enq_addr, data: enq_data, be: enq_be};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr <= '0;
            wr_data <= '0;
            wr_be   <= '0;
        end else if (load) begin
            wr_addr <= word_align(load_ent.addr);
            wr_data <= load_ent.data;
            wr_be   <= load_ent.be;
        end
    end

`ifdef STORE_FWD_EN
    sq_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd (
        .entries (mem),
        .head    (head),
        .tail    (tail),
        .ld_addr (ld_addr),
        .hit     (fwd_hit),
        .data    (fwd_data),
        .be      (fwd_be)
    );
`endif

endmodule

// File: tb/tb_store_commit_queue.sv
// Randomized and directed bench for store_commit_queue against a queue-based model.
module tb_store_commit_queue;
    import store_commit_queue_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [31:0] enq_addr = '0;
    logic [31:0] enq_data = '0;
    logic [3:0]  enq_be = '0;
    logic [1:0]  commit_cnt = '0;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        empty;
    logic        commit_err;
`ifdef STORE_FWD_EN
    logic [31:0] ld_addr = '0;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [3:0]  fwd_be;
`endif

    store_commit_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .enq_valid  (enq_valid),
        .enq_ready  (enq_ready),
        .enq_addr   (enq_addr),
        .enq_data   (enq_data),
        .enq_be     (enq_be),
        .commit_cnt (commit_cnt),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .empty      (empty),
        .commit_err (commit_err)
`ifdef STORE_FWD_EN
        ,
        .ld_addr    (ld_addr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .fwd_be     (fwd_be)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: program-order list of live stores, oldest first.
    store_entry_t sq[$];
    int  n_cmt = 0;
    bit  err_m = 0;
    bit  stall_prev = 0;
    int  wr_count = 0;
    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a negedge with inputs set for the coming posedge.
    task automatic tick();
        int  uncmt, adv;
        bit  pop, acc;
        pop = 0;
        if (!rst) begin
            if (stall_prev) chk("wr_hold", 32'(wr_valid), 32'd1);
            if (wr_valid) begin
                chk("wr_committed", 32'(n_cmt > 0), 32'd1);
                if (n_cmt > 0) begin
                    chk("wr_addr", wr_addr, sq[0].addr & 32'hFFFF_FFFC);
                    chk("wr_data", wr_data, sq[0].data);
                    chk("wr_be", 32'(wr_be), 32'(sq[0].be));
                end
            end
            pop = wr_valid && wr_ready;
        end
        if (rst) begin
            sq.delete();
            n_cmt = 0;
            err_m = 0;
            stall_prev = 0;
        end else begin
            acc   = enq_valid && (sq.size() < DEPTH) && !flush;
            uncmt = sq.size() - n_cmt;
            adv   = (int'(commit_cnt) > uncmt) ? uncmt : int'(commit_cnt);
            if (int'(commit_cnt) > uncmt) err_m = 1;
            if (pop && n_cmt > 0) begin
                void'(sq.pop_front());
                n_cmt--;
                wr_count++;
            end
            n_cmt += adv;
            if (flush) begin
                while (sq.size() > n_cmt) void'(sq.pop_back());
            end else if (acc) begin
                sq.push_back('{addr: enq_addr, data: enq_data, be: enq_be});
            end
            stall_prev = wr_valid && !wr_ready;
        end
        @(posedge clk);
        @(negedge clk);
        chk("enq_ready", 32'(enq_ready), 32'(sq.size() < DEPTH));
        chk("empty", 32'(empty), 32'(sq.size() == 0));
        chk("commit_err", 32'(commit_err), 32'(err_m));
    endtask

    task automatic idle_inputs();
        enq_valid  = 0;
        commit_cnt = 0;
        flush      = 0;
    endtask

    task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        enq_valid = 1;
        enq_addr  = a;
        enq_data  = d;
        enq_be    = be;
        tick();
        enq_valid = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        wr_ready = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic drain();
        int budget;
        int uncmt;
        idle_inputs();
        wr_ready = 1;
        budget = 0;
        while ((sq.size() != 0 || !empty) && budget < 200) begin
            uncmt = sq.size() - n_cmt;
            commit_cnt = 2'((uncmt > 2) ? 2 : uncmt);
            tick();
            budget++;
        end
        commit_cnt = 0;
        if (budget >= 200) chk("drain_timeout", 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        logic [31:0] h_addr, h_data;
        logic [3:0]  h_be;
        int          uncmt;
        int          cc;

        @(negedge clk);
        do_reset();
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_wr_be", 32'(wr_be), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_enq_ready", 32'(enq_ready), 32'd1);
        chk("rst_commit_err", 32'(commit_err), 32'd0);

        // In-order drain with two-cycle commit-to-write latency.
        wr_ready = 1;
        for (int i = 0; i < 3; i++) enq(32'h100 + 32'(4 * i), $urandom, 4'hF);
        commit_cnt = 2;
        tick();
        chk("t1_no_early_valid", 32'(wr_valid), 32'd0);
        commit_cnt = 1;
        tick();
        commit_cnt = 0;
        chk("t1_valid0", 32'(wr_valid), 32'd1);
        chk("t1_addr0", wr_addr, 32'h100);
        tick();
        chk("t1_valid1", 32'(wr_valid), 32'd1);
        chk("t1_addr1", wr_addr, 32'h104);
        tick();
        chk("t1_valid2", 32'(wr_valid), 32'd1);
        chk("t1_addr2", wr_addr, 32'h108);
        tick();
        chk("t1_idle", 32'(wr_valid), 32'd0);
        chk("t1_empty", 32'(empty), 32'd1);

        // Full queue backpressure.
        wr_ready = 0;
        for (int i = 0; i < DEPTH; i++) enq(32'h1000 + 32'(4 * i), $urandom, 4'(i));
        chk("t2_full", 32'(enq_ready), 32'd0);
        enq(32'hDEAD_0000, 32'hDEAD_BEEF, 4'hF);
        chk("t2_still_full", 32'(enq_ready), 32'd0);
        commit_cnt = 2;
        tick();
        commit_cnt = 0;
        tick();
        chk("t2_issue", 32'(wr_valid), 32'd1);
        chk("t2_no_bypass", 32'(enq_ready), 32'd0);
        wr_ready = 1;
        tick();
        wr_ready = 0;
        chk("t2_ready_after_pop", 32'(enq_ready), 32'd1);
        drain();

        // Flush keeps only committed stores.
        wr_ready = 1;
        wr_count = 0;
        for (int i = 0; i < 4; i++) enq(32'h2000 + 32'(4 * i), $urandom, 4'hF);
        commit_cnt = 1;
        tick();
        flush = 1;
        enq_valid = 1;
        enq_addr = 32'h3000;
        tick();
        idle_inputs();
        for (int i = 0; i < 10; i++) tick();
        chk("t3_write_count", 32'(wr_count), 32'd2);
        chk("t3_empty", 32'(empty), 32'd1);

        // Stall then back-to-back release.
        wr_ready = 0;
        for (int i = 0; i < 3; i++) enq(32'h4000 + 32'(4 * i), $urandom, 4'(i + 3));
        commit_cnt = 2;
        tick();
        commit_cnt = 0;
        tick();
        chk("t4_issue", 32'(wr_valid), 32'd1);
        h_addr = wr_addr;
        h_data = wr_data;
        h_be   = wr_be;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_valid", 32'(wr_valid), 32'd1);
            chk("t4_hold_addr", wr_addr, h_addr);
            chk("t4_hold_data", wr_data, h_data);
            chk("t4_hold_be", 32'(wr_be), 32'(h_be));
        end
        wr_ready = 1;
        tick();
        chk("t4_b2b_valid", 32'(wr_valid), 32'd1);
        chk("t4_b2b_addr", wr_addr, h_addr + 32'd4);
        drain();

        // Over-commit sets a sticky error.
        enq(32'h5000, 32'h1234_5678, 4'hF);
        commit_cnt = 2;
        tick();
        commit_cnt = 0;
        chk("t5_err_set", 32'(commit_err), 32'd1);
        drain();
        for (int i = 0; i < 3; i++) tick();
        chk("t5_err_sticky", 32'(commit_err), 32'd1);
        do_reset();
        chk("t5_err_cleared", 32'(commit_err), 32'd0);

`ifdef STORE_FWD_EN
        enq(32'h200, 32'h0000_00AA, 4'b0001);
        enq(32'h202, 32'hBB00_0000, 4'b1000);
        ld_addr = 32'h201;
        #1;
        chk("fwd_hit", 32'(fwd_hit), 32'd1);
        chk("fwd_data", fwd_data, 32'hBB00_0000);
        chk("fwd_be", 32'(fwd_be), 32'b1000);
        ld_addr = 32'h300;
        #1;
        chk("fwd_miss", 32'(fwd_hit), 32'd0);
        drain();
`endif

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            enq_valid  = ($urandom_range(0, 2) != 0);
            enq_addr   = $urandom;
            enq_data   = $urandom;
            enq_be     = 4'($urandom);
            wr_ready   = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 24) == 0);
            uncmt      = sq.size() - n_cmt;
            cc         = $urandom_range(0, 2);
            if ($urandom_range(0, 29) != 0 && cc > uncmt) cc = uncmt;
            commit_cnt = 2'(cc);
            tick();
        end
        drain();
        chk("final_empty", 32'(empty), 32'd1);
        chk("final_idle", 32'(wr_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/store_commit_queue.md
Name: store_commit_queue

Overview:
- Buffers stores executed by the LSU until the commit stage retires them, then drains them in order to the D-cache write port.
- Sits between the LSU store pipe, the commit stage (per-cycle committed-store count, up to 2) and the D-cache write channel.
- On a backend flush it discards only the stores not yet committed; committed stores always reach memory.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 4.
- PTR_W, $clog2(DEPTH), index width; each pointer carries one extra wrap bit.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  backend flush; drop all uncommitted entries
- enq_valid  in  1  LSU store valid
- enq_ready  out  1  queue can accept a store
- enq_addr  in  32  store byte address
- enq_data  in  32  store data, already lane-aligned
- enq_be  in  4  byte enables
- commit_cnt  in  2  stores retiring this cycle (0..2)
- wr_valid  out  1  D-cache write request
- wr_ready  in  1  D-cache accepts the write
- wr_addr  out  32  write address {addr[31:2],2'b00}
- wr_data  out  32  write data
- wr_be  out  4  write byte enables
- empty  out  1  no entries held
- commit_err  out  1  sticky: commit_cnt exceeded the uncommitted entry count

Behaviour:
- Storage is a circular buffer with three pointers (PTR_W+1 bits each):
  - head: oldest entry.
  - cmt: first uncommitted entry.
  - tail: next free slot.
- Invariant: head ≤ cmt ≤ tail, in modulo order.
- Full when tail−head == DEPTH. Empty when tail == head.
- Reset: pointers 0, FSM IDLE, commit_err 0. Resulting outputs: wr_valid 0, wr_addr/wr_data/wr_be 0, empty 1, enq_ready 1.
- enq_ready = !full, computed from registered pointers only (no same-cycle pop bypass).
- Enqueue: on enq_valid && enq_ready && !flush, write the entry at tail and advance tail by 1.
- Commit:
  - cmt advances by min(commit_cnt, tail−cmt).
  - If commit_cnt > tail−cmt, set commit_err; it stays set until reset.
  - A store enqueued in cycle N can be committed no earlier than cycle N+1.
- Flush: tail <= cmt after this cycle's commit is applied, so a commit in the flush cycle is honoured. Any enqueue in the flush cycle is dropped.
- Drain FSM:
  - IDLE: if cmt != head, load head entry into output registers and go to ISSUE (wr_valid asserts the next cycle).
  - ISSUE: wr_valid=1; outputs held stable until wr_ready.
  - On the wr_valid && wr_ready handshake, head increments. If another committed entry exists (cmt != head+1), load it and stay in ISSUE, giving back-to-back writes of 1 per cycle. Otherwise go to IDLE and wr_valid=0.
- Latency: a commit in cycle N gives wr_valid in cycle N+2 at the earliest when the FSM is IDLE.
- Flush never affects head or an in-flight ISSUE, since the entry being issued is always committed.
- Reset mid-ISSUE drops the request immediately: wr_valid is 0 in the next cycle.
- Simultaneous events: enqueue at tail, commit at cmt and pop at head may all occur in one cycle.
  - A full queue still rejects enqueue in a cycle where it pops.
- Pointer wrap relies on the extra MSB; all differences are taken modulo 2^(PTR_W+1).

Optional Feature:
- Macro: STORE_FWD_EN.
- When defined, adds the following ports:
  - ld_addr (in, 32): load address to check.
  - fwd_hit (out, 1): some entry matches the load's word.
  - fwd_data (out, 32): data of the matching entry.
  - fwd_be (out, 4): byte enables of the matching entry.
- Lookup is combinational and covers all valid entries (head..tail−1, committed or not).
- The youngest entry with addr[31:2] == ld_addr[31:2] supplies fwd_data and fwd_be; fwd_hit=1.
- Not defined: the ports are absent and no compare logic is built.

Decomposition:
- Shared package gets a store_entry_t typedef (addr, data, be) and a sq_state_t enum {SQ_IDLE, SQ_ISSUE}.
- One sub-module, sq_fwd_match: a youngest-match priority select over the entry array, instantiated only under STORE_FWD_EN.

Test Plan:
- Enqueue 3 stores (0x100/0x104/0x108), commit_cnt=2, then 1 → three writes in order, starting 2 cycles after the first commit; empty=1 afterwards.
- Enqueue 8 stores → enq_ready=0. A 9th enq_valid is held off. After commit 2 and 1 handshake → enq_ready=1 in the next cycle.
- Enqueue 4, commit 1, flush in the same cycle as commit_cnt=1 → exactly 2 writes issued; tail==cmt; the remaining 2 are never written.
- wr_ready=0 for 5 cycles while ISSUE → wr_addr/data/be stay stable. Then wr_ready=1 with 2 committed → back-to-back writes in consecutive cycles.
- commit_cnt=2 with only 1 uncommitted entry → cmt advances by 1; commit_err=1 and stays set until reset.
- STORE_FWD_EN: enqueue {0x200, 0xAA, 4'b0001}, then {0x202, 0xBB00_0000, 4'b1000}; ld_addr=0x201 → fwd_hit=1, fwd_data=0xBB00_0000, fwd_be=4'b1000.
